// File: rtl/reg_file_sb.sv
// reg_file_sb: general-purpose register file with a configurable number of
// combinational read ports, a per-register busy scoreboard for issue-stage
// hazard detection, and HI/LO special registers with write-through forwarding.
// Register 0 reads as zero and can never be written or reserved.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int RD_PORTS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  // Read ports (issue stage)
  input  logic [RD_PORTS-1:0]          rd_en,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data,
  output logic [RD_PORTS-1:0]          rd_busy,
  // Writeback port
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  // Destination reservation (issue of a producing instruction)
  input  logic                         rsv_en,
  input  logic [ADDR_W-1:0]            rsv_addr,
  // HI/LO special registers
  input  logic                         hilo_we,
  input  logic [DATA_W-1:0]            hi_wdata,
  input  logic [DATA_W-1:0]            lo_wdata,
  output logic [DATA_W-1:0]            hi_data,
  output logic [DATA_W-1:0]            lo_data,
  // Scoreboard occupancy
  output logic [ADDR_W:0]              busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [ADDR_W:0]   busy_pop;

  // Address 0 is architecturally constant, so writes and reservations to it
  // are dropped before they reach any state.
  logic wr_fire;
  logic rsv_fire;

  assign wr_fire  = wr_en  && (wr_addr  != '0);
  assign rsv_fire = rsv_en && (rsv_addr != '0);

  // ---------------------------------------------------------------------------
  // Register array: writeback updates one entry per edge
  // ---------------------------------------------------------------------------
  // NOTE: the array is cleared on reset because reads must return 0 after a
  // reset even for registers never written since; this costs a reset net on
  // every flop, so it is a deliberate choice and not a default.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_fire) begin
      // NOTE: state is always updated with <= so every flop samples the
      // pre-edge values; = here would create ordering-dependent races.
      regs_q[wr_addr] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard next state: writeback clears, reservation sets, set wins
  // ---------------------------------------------------------------------------
  // NOTE: busy_d is given its full default before any conditional update, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    busy_d = busy_q;
    if (wr_fire) begin
      busy_d[wr_addr] = 1'b0;
    end
    // Applied after the clear: on a same-edge write and reservation of one
    // register the new producer keeps it busy.
    if (rsv_fire) begin
      busy_d[rsv_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // HI/LO registers: both written together
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (hilo_we) begin
      hi_q <= hi_wdata;
      lo_q <= lo_wdata;
    end
  end

  // Forward the incoming HI/LO values in the cycle they are written.
  assign hi_data = rst ? '0 : (hilo_we ? hi_wdata : hi_q);
  assign lo_data = rst ? '0 : (hilo_we ? lo_wdata : lo_q);

  // ---------------------------------------------------------------------------
  // Busy population count, taken from the stored scoreboard only
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_pop = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_pop = busy_pop + {{ADDR_W{1'b0}}, busy_q[i]};
    end
  end

  // Register 0 is never busy, so the count tops out at DEPTH-1 and fits.
  assign busy_cnt = rst ? '0 : busy_pop;

  // ---------------------------------------------------------------------------
  // Read ports: fully independent, each with its own writeback bypass
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < RD_PORTS; g++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              live;
    logic              wr_hit;

    assign addr   = rd_addr[g*ADDR_W +: ADDR_W];
    // A port produces data only outside reset, when enabled, and not for r0.
    assign live   = !rst && rd_en[g] && (addr != '0);
    // Same-cycle writeback to the read address: forward it and treat the
    // hazard as resolved. wr_addr == addr with addr != 0 implies wr_fire.
    assign wr_hit = wr_en && (wr_addr == addr);

    assign rd_data[g*DATA_W +: DATA_W] = !live  ? '0      :
                                         wr_hit ? wr_data :
                                                  regs_q[addr];

    // A same-cycle reservation is deliberately not visible here: busy only
    // shows from the cycle after the reserving edge.
    assign rd_busy[g] = live && busy_q[addr] && !wr_hit;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed testbench for reg_file_sb: reset behaviour, bypassing, register 0,
// scoreboard set/clear/collision, HI/LO forwarding and asynchronous reset.
module tb_reg_file_sb;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int RD_PORTS = 2;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [RD_PORTS-1:0]        rd_en;
  logic [RD_PORTS*ADDR_W-1:0] rd_addr;
  logic [RD_PORTS*DATA_W-1:0] rd_data;
  logic [RD_PORTS-1:0]        rd_busy;
  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic                       rsv_en;
  logic [ADDR_W-1:0]          rsv_addr;
  logic                       hilo_we;
  logic [DATA_W-1:0]          hi_wdata;
  logic [DATA_W-1:0]          lo_wdata;
  logic [DATA_W-1:0]          hi_data;
  logic [DATA_W-1:0]          lo_data;
  logic [ADDR_W:0]            busy_cnt;

  int checks = 0;
  int errors = 0;

  reg_file_sb #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .RD_PORTS(RD_PORTS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_busy (rd_busy),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rsv_en  (rsv_en),
    .rsv_addr(rsv_addr),
    .hilo_we (hilo_we),
    .hi_wdata(hi_wdata),
    .lo_wdata(lo_wdata),
    .hi_data (hi_data),
    .lo_data (lo_data),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rd(input int k, input logic en, input logic [ADDR_W-1:0] a);
    rd_en[k] = en;
    rd_addr[k*ADDR_W +: ADDR_W] = a;
  endtask

  function automatic logic [DATA_W-1:0] port_data(input int k);
    return rd_data[k*DATA_W +: DATA_W];
  endfunction

  task automatic idle();
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
    hilo_we  = 1'b0;
    hi_wdata = '0;
    lo_wdata = '0;
  endtask

  // Advance through one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- Reset with random activity on every input -------------
    rst      = 1'b1;
    rd_en    = '1;
    rd_addr  = $urandom();
    wr_en    = 1'b1;
    wr_addr  = ADDR_W'($urandom_range(1, 31));
    wr_data  = $urandom();
    rsv_en   = 1'b1;
    rsv_addr = ADDR_W'($urandom_range(1, 31));
    hilo_we  = 1'b1;
    hi_wdata = $urandom() | 32'h1;
    lo_wdata = $urandom() | 32'h1;
    set_rd(0, 1'b1, wr_addr);
    #2;
    check("rst_rd_data", 64'(rd_data), 64'h0);
    check("rst_rd_busy", 64'(rd_busy), 64'h0);
    check("rst_hi", 64'(hi_data), 64'h0);
    check("rst_lo", 64'(lo_data), 64'h0);
    check("rst_busy_cnt", 64'(busy_cnt), 64'h0);
    tick();
    tick();
    check("rst_edge_rd_data", 64'(rd_data), 64'h0);
    check("rst_edge_busy_cnt", 64'(busy_cnt), 64'h0);

    // Release reset between edges with the bus idle.
    idle();
    rst = 1'b0;
    set_rd(0, 1'b1, 5'd5);
    set_rd(1, 1'b1, 5'd6);
    #1;
    check("post_rst_rd0", 64'(port_data(0)), 64'h0);
    check("post_rst_rd1", 64'(port_data(1)), 64'h0);
    check("post_rst_busy_cnt", 64'(busy_cnt), 64'h0);
    check("post_rst_hi", 64'(hi_data), 64'h0);
    tick();

    // ---------------- Write with same-cycle bypass ---------------------------
    wr_en   = 1'b1;
    wr_addr = 5'd5;
    wr_data = 32'hDEADBEEF;
    #1;
    check("bypass_rd0", 64'(port_data(0)), 64'hDEADBEEF);
    check("bypass_other_rd1", 64'(port_data(1)), 64'h0);
    tick();
    idle();
    #1;
    check("array_rd0", 64'(port_data(0)), 64'hDEADBEEF);
    check("array_rd1", 64'(port_data(1)), 64'h0);
    // Identical addresses on both ports return identical data.
    set_rd(1, 1'b1, 5'd5);
    #1;
    check("same_addr_rd1", 64'(port_data(1)), 64'hDEADBEEF);
    // Disabled port reads 0 even on a written register.
    set_rd(1, 1'b0, 5'd5);
    #1;
    check("disabled_rd1", 64'(port_data(1)), 64'h0);

    // ---------------- Register 0 --------------------------------------------
    wr_en    = 1'b1;
    wr_addr  = 5'd0;
    wr_data  = 32'h12345678;
    rsv_en   = 1'b1;
    rsv_addr = 5'd0;
    set_rd(0, 1'b1, 5'd0);
    set_rd(1, 1'b1, 5'd0);
    #1;
    check("r0_bypass_rd0", 64'(port_data(0)), 64'h0);
    check("r0_bypass_rd1", 64'(port_data(1)), 64'h0);
    tick();
    idle();
    #1;
    check("r0_rd0", 64'(port_data(0)), 64'h0);
    check("r0_busy", 64'(rd_busy), 64'h0);
    check("r0_busy_cnt", 64'(busy_cnt), 64'h0);

    // ---------------- Scoreboard --------------------------------------------
    set_rd(0, 1'b1, 5'd3);
    set_rd(1, 1'b1, 5'd7);
    rsv_en   = 1'b1;
    rsv_addr = 5'd3;
    #1;
    check("rsv_same_cycle_busy0", 64'(rd_busy[0]), 64'h0);
    tick();
    rsv_addr = 5'd7;
    #1;
    check("rsv3_busy0", 64'(rd_busy[0]), 64'h1);
    check("rsv3_busy_cnt", 64'(busy_cnt), 64'd1);
    tick();
    idle();
    #1;
    check("rsv37_busy_cnt", 64'(busy_cnt), 64'd2);
    check("rsv37_busy", 64'(rd_busy), 64'h3);
    // Writeback of 3 resolves the hazard in the same cycle.
    wr_en   = 1'b1;
    wr_addr = 5'd3;
    wr_data = 32'hA5;
    #1;
    check("wb3_busy", 64'(rd_busy), 64'h2);
    check("wb3_rd0", 64'(port_data(0)), 64'hA5);
    check("wb3_cnt_before_edge", 64'(busy_cnt), 64'd2);
    tick();
    idle();
    #1;
    check("wb3_cnt_after_edge", 64'(busy_cnt), 64'd1);
    check("wb3_rd0_array", 64'(port_data(0)), 64'hA5);
    check("wb3_busy_after", 64'(rd_busy), 64'h2);

    // Reserving an already-busy register leaves the count alone.
    rsv_en   = 1'b1;
    rsv_addr = 5'd7;
    tick();
    idle();
    #1;
    check("rsv_again_cnt", 64'(busy_cnt), 64'd1);

    // ---------------- Write/reserve collision on 9 ---------------------------
    rsv_en   = 1'b1;
    rsv_addr = 5'd9;
    tick();
    idle();
    set_rd(0, 1'b1, 5'd9);
    #1;
    check("pre_coll_cnt", 64'(busy_cnt), 64'd2);
    check("pre_coll_busy0", 64'(rd_busy[0]), 64'h1);
    wr_en    = 1'b1;
    wr_addr  = 5'd9;
    wr_data  = 32'h99;
    rsv_en   = 1'b1;
    rsv_addr = 5'd9;
    #1;
    check("coll_busy0_same_cycle", 64'(rd_busy[0]), 64'h0);
    tick();
    idle();
    #1;
    check("coll_cnt", 64'(busy_cnt), 64'd2);
    check("coll_busy0", 64'(rd_busy[0]), 64'h1);
    check("coll_rd0", 64'(port_data(0)), 64'h99);

    // ---------------- HI/LO forwarding --------------------------------------
    hilo_we  = 1'b1;
    hi_wdata = 32'h1;
    lo_wdata = 32'h2;
    #1;
    check("hilo_fwd_hi", 64'(hi_data), 64'h1);
    check("hilo_fwd_lo", 64'(lo_data), 64'h2);
    tick();
    idle();
    hi_wdata = 32'hFF;
    lo_wdata = 32'hEE;
    #1;
    check("hilo_hold_hi", 64'(hi_data), 64'h1);
    check("hilo_hold_lo", 64'(lo_data), 64'h2);

    // ---------------- Asynchronous reset mid-cycle --------------------------
    set_rd(0, 1'b1, 5'd5);
    set_rd(1, 1'b1, 5'd7);
    #1;
    check("pre_arst_rd0", 64'(port_data(0)), 64'hDEADBEEF);
    check("pre_arst_busy1", 64'(rd_busy[1]), 64'h1);
    rst = 1'b1;
    #1;
    check("arst_hi", 64'(hi_data), 64'h0);
    check("arst_lo", 64'(lo_data), 64'h0);
    check("arst_busy_cnt", 64'(busy_cnt), 64'h0);
    check("arst_rd_data", 64'(rd_data), 64'h0);
    check("arst_rd_busy", 64'(rd_busy), 64'h0);
    rst = 1'b0;
    #1;
    check("arst_rel_rd0", 64'(port_data(0)), 64'h0);
    check("arst_rel_busy1", 64'(rd_busy[1]), 64'h0);
    check("arst_rel_cnt", 64'(busy_cnt), 64'h0);
    check("arst_rel_hi", 64'(hi_data), 64'h0);

    // First edge after reset release performs a write and a reservation.
    wr_en    = 1'b1;
    wr_addr  = 5'd4;
    wr_data  = 32'h44;
    rsv_en   = 1'b1;
    rsv_addr = 5'd12;
    tick();
    idle();
    set_rd(0, 1'b1, 5'd4);
    set_rd(1, 1'b1, 5'd12);
    #1;
    check("first_edge_rd0", 64'(port_data(0)), 64'h44);
    check("first_edge_busy1", 64'(rd_busy[1]), 64'h1);
    check("first_edge_cnt", 64'(busy_cnt), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
